// File: rtl/sa_result_writeback.sv
// Drain side of the systolic array: deskews per-column accumulator results and
// writes each completed result row into the vector register file.
module sa_result_writeback #(
   parameter int X               = 3,
   parameter int Y               = 3,
   parameter int ADD_DATAWIDTH   = 32,
   parameter int NUM_REGS        = 8,
   parameter int NUM_REG_ROWS    = 16,
   parameter int NUM_REG_COLUMNS = 64,
   parameter int FIFO_DEPTH      = 4
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 cmd_valid,
   output logic                                 cmd_ready,
   input  logic [$clog2(NUM_REGS)-1:0]          cmd_reg,
   input  logic [$clog2(NUM_REG_ROWS)-1:0]      cmd_row,
   input  logic [$clog2(NUM_REG_ROWS):0]        cmd_rows,
   input  logic [Y-1:0]                         col_valid,
   input  logic [Y*ADD_DATAWIDTH-1:0]           col_data,
   output logic                                 wr_valid,
   input  logic                                 wr_ready,
   output logic [$clog2(NUM_REGS)-1:0]          wr_reg,
   output logic [$clog2(NUM_REG_ROWS)-1:0]      wr_row,
   output logic [NUM_REG_COLUMNS*8-1:0]         wr_data,
   output logic [NUM_REG_COLUMNS-1:0]           wr_byte_en,
   output logic                                 busy,
   output logic                                 done,
   output logic                                 overflow
);

   // state  | meaning
   // IDLE   | waiting for a drain command, cmd_ready=1
   // DRAIN  | collecting column results and writing rows
   // DONE   | one-cycle completion pulse, then back to IDLE

   localparam int REG_W  = $clog2(NUM_REGS);
   localparam int ROW_W  = $clog2(NUM_REG_ROWS);
   localparam int CNT_W  = ROW_W + 1;
   localparam int DATA_W = NUM_REG_COLUMNS * 8;
   localparam int AW     = $clog2(FIFO_DEPTH);
   localparam int USED_B = Y * ADD_DATAWIDTH / 8;
   localparam logic [NUM_REG_COLUMNS-1:0] BE_MASK =
      {{(NUM_REG_COLUMNS - USED_B){1'b0}}, {USED_B{1'b1}}};

   if (FIFO_DEPTH < Y || X < 1) begin : g_bad_cfg
      $error("sa_result_writeback: FIFO_DEPTH must cover the column skew");
   end

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DRAIN = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic                      accept;
   logic                      wr_fire;
   logic                      pop;
   logic                      drop_any;
   logic [Y-1:0]              fifo_empty;
   logic [Y-1:0]              fifo_full;
   logic [Y-1:0]              push;
   logic [DATA_W-1:0]         row_pack;

   logic [ADD_DATAWIDTH-1:0]  fifo_mem [Y][FIFO_DEPTH];
   logic [AW:0]               wptr [Y];
   logic [AW:0]               rptr [Y];

   logic [REG_W-1:0]          reg_q;
   logic [ROW_W-1:0]          next_row;
   logic [CNT_W-1:0]          rows_left;
   logic [CNT_W-1:0]          rows_to_pop;

   assign wr_fire = wr_valid && wr_ready;

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      cmd_ready = 1'b0;
      busy      = 1'b1;
      done      = 1'b0;
      case (state)
         S_IDLE: begin
            cmd_ready = 1'b1;
            busy      = 1'b0;
            if (cmd_valid) begin
               accept    = 1'b1;
               state_nxt = (cmd_rows == '0) ? S_DONE : S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (wr_fire && rows_left == CNT_W'(1)) begin
               state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            done      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // rows_to_pop bounds loads into the output stage; rows_left bounds handshakes.
   always_comb begin
      pop      = 1'b0;
      drop_any = 1'b0;
      push     = '0;
      row_pack = '0;
      for (int j = 0; j < Y; j++) begin
         fifo_empty[j] = (wptr[j] == rptr[j]);
         fifo_full[j]  = (wptr[j][AW] != rptr[j][AW]) &&
                         (wptr[j][AW-1:0] == rptr[j][AW-1:0]);
         row_pack[j*ADD_DATAWIDTH +: ADD_DATAWIDTH] = fifo_mem[j][rptr[j][AW-1:0]];
      end
      if (state == S_DRAIN && fifo_empty == '0 && rows_to_pop != '0 &&
          (!wr_valid || wr_ready)) begin
         pop = 1'b1;
      end
      for (int j = 0; j < Y; j++) begin
         if (state == S_DRAIN && col_valid[j]) begin
            if (!fifo_full[j] || pop) begin
               push[j] = 1'b1;
            end else begin
               drop_any = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int j = 0; j < Y; j++) begin
         if (push[j]) begin
            fifo_mem[j][wptr[j][AW-1:0]] <= col_data[j*ADD_DATAWIDTH +: ADD_DATAWIDTH];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int j = 0; j < Y; j++) begin
            wptr[j] <= '0;
            rptr[j] <= '0;
         end
      end else if (accept) begin
         for (int j = 0; j < Y; j++) begin
            wptr[j] <= '0;
            rptr[j] <= '0;
         end
      end else begin
         for (int j = 0; j < Y; j++) begin
            if (push[j]) begin
               wptr[j] <= wptr[j] + (AW+1)'(1);
            end
            if (pop) begin
               rptr[j] <= rptr[j] + (AW+1)'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         reg_q       <= '0;
         next_row    <= '0;
         rows_left   <= '0;
         rows_to_pop <= '0;
         overflow    <= 1'b0;
      end else if (accept) begin
         reg_q       <= cmd_reg;
         next_row    <= cmd_row;
         rows_left   <= cmd_rows;
         rows_to_pop <= cmd_rows;
         overflow    <= 1'b0;
      end else begin
         if (pop) begin
            next_row    <= next_row + ROW_W'(1);
            rows_to_pop <= rows_to_pop - CNT_W'(1);
         end
         if (wr_fire) begin
            rows_left <= rows_left - CNT_W'(1);
         end
         if (drop_any) begin
            overflow <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_valid   <= 1'b0;
         wr_reg     <= '0;
         wr_row     <= '0;
         wr_data    <= '0;
         wr_byte_en <= '0;
      end else if (pop) begin
         wr_valid   <= 1'b1;
         wr_reg     <= reg_q;
         wr_row     <= next_row;
         wr_data    <= row_pack;
         wr_byte_en <= BE_MASK;
      end else if (wr_fire) begin
         wr_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_sa_result_writeback.sv
// Scoreboard bench for sa_result_writeback: expected rows are queued as column
// data is driven and compared at each register-file write handshake.
module tb_sa_result_writeback;

   localparam int Y = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [2:0]    cmd_reg = '0;
   logic [3:0]    cmd_row = '0;
   logic [4:0]    cmd_rows = '0;
   logic [Y-1:0]  col_valid = '0;
   logic [Y*32-1:0] col_data = '0;
   logic          wr_valid;
   logic          wr_ready = 1'b1;
   logic [2:0]    wr_reg;
   logic [3:0]    wr_row;
   logic [511:0]  wr_data;
   logic [63:0]   wr_byte_en;
   logic          busy;
   logic          done;
   logic          overflow;

   sa_result_writeback dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_reg(cmd_reg), .cmd_row(cmd_row), .cmd_rows(cmd_rows),
      .col_valid(col_valid), .col_data(col_data),
      .wr_valid(wr_valid), .wr_ready(wr_ready),
      .wr_reg(wr_reg), .wr_row(wr_row), .wr_data(wr_data), .wr_byte_en(wr_byte_en),
      .busy(busy), .done(done), .overflow(overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]   r;
      logic [3:0]   row;
      logic [511:0] d;
   } exp_t;

   exp_t sb[$];
   int n_checks = 0;
   int n_fail = 0;
   int cyc = 0;
   int first_valid_cyc = -1;
   int last_hs_cyc = -1;
   int hs_count = 0;

   logic         prev_stall = 1'b0;
   logic [2:0]   s_reg;
   logic [3:0]   s_row;
   logic [511:0] s_data;
   logic [63:0]  s_be;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [511:0] pack_row(logic [31:0] a, logic [31:0] b, logic [31:0] c);
      logic [511:0] v;
      v = '0;
      v[31:0]  = a;
      v[63:32] = b;
      v[95:64] = c;
      return v;
   endfunction

   // write-port monitor: stall stability and scoreboard compare
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            n_checks++;
            if (wr_valid !== 1'b1 || wr_reg !== s_reg || wr_row !== s_row ||
                wr_data !== s_data || wr_byte_en !== s_be) begin
               n_fail++;
               $display("FAIL hold_stable: valid=%b reg=%0d row=%0d data=%h required held reg=%0d row=%0d data=%h",
                        wr_valid, wr_reg, wr_row, wr_data[95:0], s_reg, s_row, s_data[95:0]);
            end
         end
         if (wr_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
         if (wr_valid === 1'b1 && wr_ready === 1'b1) begin
            hs_count++;
            last_hs_cyc = cyc;
            n_checks++;
            if (sb.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_write: reg=%0d row=%0d data=%h required no write",
                        wr_reg, wr_row, wr_data[95:0]);
            end else begin
               e = sb.pop_front();
               if (wr_reg !== e.r || wr_row !== e.row || wr_data !== e.d ||
                   wr_byte_en !== 64'h0FFF) begin
                  n_fail++;
                  $display("FAIL write_row: got reg=%0d row=%0d data=%h be=%h required reg=%0d row=%0d data=%h be=0fff",
                           wr_reg, wr_row, wr_data[95:0], wr_byte_en, e.r, e.row, e.d[95:0]);
               end
            end
         end
         prev_stall = (wr_valid === 1'b1) && (wr_ready !== 1'b1);
         s_reg = wr_reg; s_row = wr_row; s_data = wr_data; s_be = wr_byte_en;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue_cmd(input logic [2:0] r, input logic [3:0] row, input logic [4:0] rows);
      cmd_valid = 1'b1;
      cmd_reg = r;
      cmd_row = row;
      cmd_rows = rows;
      first_valid_cyc = -1;
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic feed_skewed(input logic [2:0] r, input logic [3:0] row, input int rows,
                              input logic [31:0] base, output int last0_cyc);
      exp_t e;
      last0_cyc = -1;
      for (int k = 0; k < rows; k++) begin
         e.r = r;
         e.row = 4'(int'(row) + k);
         e.d = pack_row(base + 32'h100*k, base + 32'h100*k + 1, base + 32'h100*k + 2);
         sb.push_back(e);
      end
      for (int t = 0; t < rows + Y - 1; t++) begin
         for (int j = 0; j < Y; j++) begin
            col_valid[j] = (t - j >= 0) && (t - j < rows);
            col_data[j*32 +: 32] = base + 32'h100*(t - j) + j;
         end
         if (t == Y - 1) last0_cyc = cyc;
         tick();
      end
      col_valid = '0;
   endtask

   task automatic feed_aligned(input logic [2:0] r, input logic [3:0] row, input int k,
                               input logic [31:0] base);
      exp_t e;
      e.r = r;
      e.row = 4'(int'(row) + k);
      e.d = pack_row(base, base + 1, base + 2);
      sb.push_back(e);
      col_valid = '1;
      for (int j = 0; j < Y; j++) col_data[j*32 +: 32] = base + j;
      tick();
      col_valid = '0;
   endtask

   task automatic wait_done(input string name, output int done_cyc);
      done_cyc = -1;
      for (int i = 0; i < 60 && done_cyc < 0; i++) begin
         @(negedge clk);
         if (done === 1'b1) done_cyc = cyc;
      end
      n_checks++;
      if (done_cyc < 0) begin
         n_fail++;
         $display("FAIL %s_done_timeout: done never seen, required a done pulse", name);
      end else begin
         @(negedge clk);
         n_checks++;
         if (done !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_after_done: done=%b cmd_ready=%b busy=%b required 0 1 0",
                     name, done, cmd_ready, busy);
         end
      end
      tick();
   endtask

   task automatic check_sb_empty(input string name);
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL %s_rows_lost: %0d rows unwritten, required 0", name, sb.size());
      end
   endtask

   task automatic test_reset();
      #2;
      n_checks++;
      if (cmd_ready !== 1'b1 || wr_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
          overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: cmd_ready=%b wr_valid=%b busy=%b done=%b overflow=%b required 1 0 0 0 0",
                  cmd_ready, wr_valid, busy, done, overflow);
      end
      n_checks++;
      if (wr_reg !== 3'd0 || wr_row !== 4'd0 || wr_data !== '0 || wr_byte_en !== '0) begin
         n_fail++;
         $display("FAIL reset_data: reg=%0d row=%0d data=%h be=%h required all zero",
                  wr_reg, wr_row, wr_data[95:0], wr_byte_en);
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_skewed();
      int c0, dc;
      wr_ready = 1'b1;
      issue_cmd(3'd2, 4'd0, 5'd3);
      n_checks++;
      if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL skew_busy: cmd_ready=%b busy=%b required 0 1", cmd_ready, busy);
      end
      feed_skewed(3'd2, 4'd0, 3, 32'h0, c0);
      wait_done("skew", dc);
      n_checks++;
      if (first_valid_cyc != c0 + 2) begin
         n_fail++;
         $display("FAIL skew_latency: first wr_valid cycle %0d required %0d", first_valid_cyc, c0 + 2);
      end
      n_checks++;
      if (last_hs_cyc != first_valid_cyc + 2) begin
         n_fail++;
         $display("FAIL back_to_back: last write cycle %0d required %0d", last_hs_cyc, first_valid_cyc + 2);
      end
      n_checks++;
      if (dc != last_hs_cyc + 1) begin
         n_fail++;
         $display("FAIL skew_done_timing: done cycle %0d required %0d", dc, last_hs_cyc + 1);
      end
      check_sb_empty("skew");
   endtask

   task automatic test_wrap();
      int c0, dc, hs0;
      hs0 = hs_count;
      issue_cmd(3'd6, 4'd14, 5'd4);
      feed_skewed(3'd6, 4'd14, 4, 32'h5000, c0);
      wait_done("wrap", dc);
      n_checks++;
      if (hs_count - hs0 != 4) begin
         n_fail++;
         $display("FAIL wrap_count: %0d writes required 4", hs_count - hs0);
      end
      check_sb_empty("wrap");
   endtask

   task automatic test_backpressure();
      int dc, hs0;
      wr_ready = 1'b0;
      issue_cmd(3'd5, 4'd3, 5'd6);
      for (int k = 0; k < 5; k++) feed_aligned(3'd5, 4'd3, k, 32'hA000 + 32'h10*k);
      hs0 = hs_count;
      for (int i = 0; i < 5; i++) tick();
      n_checks++;
      if (wr_valid !== 1'b1 || overflow !== 1'b0 || hs_count != hs0) begin
         n_fail++;
         $display("FAIL bp_stall: wr_valid=%b overflow=%b writes=%0d required 1 0 0",
                  wr_valid, overflow, hs_count - hs0);
      end
      wr_ready = 1'b1;
      tick();
      tick();
      feed_aligned(3'd5, 4'd3, 5, 32'hA050);
      wait_done("bp", dc);
      n_checks++;
      if (overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_overflow: overflow=%b required 0", overflow);
      end
      check_sb_empty("bp");
   endtask

   task automatic test_overflow();
      int dc;
      exp_t e;
      wr_ready = 1'b0;
      issue_cmd(3'd3, 4'd8, 5'd4);
      for (int k = 0; k < 5; k++) begin
         col_valid = 3'b001;
         col_data[31:0] = 32'hC000 + k;
         tick();
         if (k == 3) begin
            n_checks++;
            if (overflow !== 1'b0) begin
               n_fail++;
               $display("FAIL ovf_early: overflow=%b after 4 pushes required 0", overflow);
            end
         end
      end
      n_checks++;
      if (overflow !== 1'b1) begin
         n_fail++;
         $display("FAIL ovf_set: overflow=%b after 5th push required 1", overflow);
      end
      for (int k = 0; k < 4; k++) begin
         e.r = 3'd3;
         e.row = 4'(8 + k);
         e.d = pack_row(32'hC000 + k, 32'hD100 + k, 32'hD200 + k);
         sb.push_back(e);
         col_valid = 3'b110;
         col_data[63:32] = 32'hD100 + k;
         col_data[95:64] = 32'hD200 + k;
         tick();
      end
      col_valid = '0;
      tick();
      wr_ready = 1'b1;
      wait_done("ovf", dc);
      n_checks++;
      if (overflow !== 1'b1) begin
         n_fail++;
         $display("FAIL ovf_sticky: overflow=%b after done required 1", overflow);
      end
      check_sb_empty("ovf");
   endtask

   task automatic test_zero_idle();
      int c0, dc;
      for (int i = 0; i < 3; i++) begin
         col_valid = '1;
         col_data = {32'hBAD2, 32'hBAD1, 32'hBAD0};
         tick();
      end
      col_valid = '0;
      issue_cmd(3'd1, 4'd2, 5'd0);
      n_checks++;
      if (done !== 1'b1 || overflow !== 1'b0 || wr_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL zero_done: done=%b overflow=%b wr_valid=%b required 1 0 0",
                  done, overflow, wr_valid);
      end
      tick();
      n_checks++;
      if (done !== 1'b0 || cmd_ready !== 1'b1 || wr_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL zero_idle: done=%b cmd_ready=%b wr_valid=%b required 0 1 0",
                  done, cmd_ready, wr_valid);
      end
      issue_cmd(3'd4, 4'd9, 5'd1);
      feed_skewed(3'd4, 4'd9, 1, 32'h7700, c0);
      wait_done("idle_strobe", dc);
      check_sb_empty("idle_strobe");
   endtask

   task automatic test_reset_mid();
      int c0, dc, seen_done;
      wr_ready = 1'b0;
      issue_cmd(3'd7, 4'd2, 5'd2);
      feed_aligned(3'd7, 4'd2, 0, 32'hE000);
      for (int i = 0; i < 10 && wr_valid !== 1'b1; i++) tick();
      n_checks++;
      if (wr_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL rstmid_pending: wr_valid=%b required 1", wr_valid);
      end
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (wr_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL rstmid_abort: wr_valid=%b busy=%b cmd_ready=%b done=%b required 0 0 1 0",
                  wr_valid, busy, cmd_ready, done);
      end
      sb.delete();
      wr_ready = 1'b1;
      tick();
      @(negedge clk);
      rst_n = 1'b1;
      seen_done = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (done === 1'b1) seen_done++;
      end
      n_checks++;
      if (seen_done != 0) begin
         n_fail++;
         $display("FAIL rstmid_no_done: %0d done pulses required 0", seen_done);
      end
      tick();
      issue_cmd(3'd1, 4'd5, 5'd2);
      feed_skewed(3'd1, 4'd5, 2, 32'hF000, c0);
      wait_done("post_rst", dc);
      check_sb_empty("post_rst");
   endtask

   initial begin
      test_reset();
      test_skewed();
      test_wrap();
      test_backpressure();
      test_overflow();
      test_zero_idle();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
